gpio_modport: RTL and testbench
===============================

# gpio_modport

APB4 slave general-purpose I/O block with per-pin direction, push-pull/open-drain mode, a synchronized input readback and an edge/level interrupt controller. It sits on the peripheral APB bus and drives SoC pads through separate output, output-enable and input vectors. Its single interrupt line goes to the system interrupt controller.

## Interface
- PADDR_SIZE, default 8: APB address width; must be at least 6.
- PDATA_SIZE, default 32: APB data width and GPIO pin count; must be a multiple of 8.
- PCLK, input, 1: sole clock; all logic is on its rising edge.
- PRESETn, input, 1: reset; synchronous and active-low.
- PSEL, input, 1: slave select.
- PENABLE, input, 1: APB access phase.
- PADDR, input, PADDR_SIZE: byte address; bits [5:2] select the register.
- PWRITE, input, 1: 1 = write, 0 = read.
- PSTRB, input, PDATA_SIZE/8: write byte enables.
- PWDATA, input, PDATA_SIZE: write data.
- PRDATA, output, PDATA_SIZE: read data.
- PREADY, output, 1: transfer complete.
- PSLVERR, output, 1: transfer error.
- gpio_i, input, PDATA_SIZE: asynchronous pad inputs.
- gpio_o, output, PDATA_SIZE: pad output values.
- gpio_oe, output, PDATA_SIZE: pad output enables; 1 = pin is driven.
- irq_o, output, 1: level-high interrupt.

## Operation
- Register map (byte offsets). All registers are RW except where stated.
  - 0x00 MODE: 1 = open-drain, 0 = push-pull.
  - 0x04 DIR: 1 = output.
  - 0x08 OUT: output values.
  - 0x0C IN: read-only; synchronized gpio_i.
  - 0x10 TR_TYPE: 1 = edge trigger, 0 = level trigger.
  - 0x14 TR_LVL0: enables falling-edge or low-level triggering.
  - 0x18 TR_LVL1: enables rising-edge or high-level triggering.
  - 0x1C TR_STAT: sticky status; write-1-to-clear.
  - 0x20 IRQ_ENA: bit 0 = global interrupt enable; upper bits read 0.
- Write commit: a write takes effect at the PCLK edge where PSEL, PENABLE and PWRITE are all 1. Only bytes with the matching PSTRB bit set are written.
- PREADY is constantly 1, so every transfer has zero wait states.
- PSLVERR is 1 during the access phase (PSEL & PENABLE) for any of these, and 0 otherwise:
  - an unmapped offset;
  - a write to IN;
  - PADDR[1:0] != 0.
- A transfer that flags PSLVERR has no effect on any register.
- PRDATA is combinational: the selected register when PSEL is 1, PWRITE is 0 and the offset is mapped; 0 otherwise.
- Pad outputs per pin:
  - push-pull: gpio_o = OUT, gpio_oe = DIR;
  - open-drain: gpio_o = 0, gpio_oe = DIR & ~OUT.
- Trigger condition per pin, evaluated on the synchronized input s and its previous value p:
  - edge trigger: (LVL1 & s & ~p) | (LVL0 & ~s & p);
  - level trigger: (LVL1 & s) | (LVL0 & ~s).
- A true trigger condition sets the TR_STAT bit. If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- irq_o = IRQ_ENA[0] & |TR_STAT. It is a combinational output of flops only.
- Reset values: every register is 0, the synchronizer flops are 0, and irq_o, PRDATA and PSLVERR are 0. At reset all pins are undriven inputs (gpio_oe = 0, gpio_o = 0).

## Timing
- Input path: a gpio_i change captured at edge k appears in IN after edge k+1 (two-flop synchronizer).
- Interrupt path: the resulting TR_STAT bit sets at edge k+2, and irq_o rises immediately after it.
- Register writes update their outputs (gpio_o, gpio_oe, irq_o) right after the committing edge.
- Reads: data is valid throughout setup and access phases. A read in the same cycle as a status set returns the pre-edge value.
- While PRESETn is low, all state holds its reset value; a transfer issued during reset is ignored.

## Configuration
- GPIO_IRQ_EN defined: TR_TYPE, TR_LVL0, TR_LVL1, TR_STAT, IRQ_ENA and irq_o are implemented as above.
- GPIO_IRQ_EN undefined:
  - those five registers are absent, and offsets 0x10–0x20 are unmapped, so they return PSLVERR and read 0;
  - irq_o is tied to 0;
  - the synchronizer is still present.

## Structure
- Package gpio_modport_pkg holds:
  - register offset constants and the default widths;
  - the register-index enum.
- Sub-module gpio_modport_sync: a PDATA_SIZE-wide two-flop synchronizer plus a previous-value flop. It outputs s and p.

## Test plan
- Reset: assert PRESETn = 0 for 3 cycles → all reads return 0, gpio_oe = 0, irq_o = 0.
- Push-pull output: write DIR = 0x0000_00FF, then OUT = 0x0000_00A5 → gpio_oe = 0xFF, gpio_o = 0xA5. Then write MODE = 0xFF (open-drain) → gpio_o = 0, gpio_oe = 0x5A.
- Byte strobes: write OUT = 0xFFFF_FFFF with PSTRB = 4'b0010 → OUT reads 0x0000_FF00.
- Input readback: drive gpio_i = 0x1234_5678 → IN reads 0x1234_5678 from the third cycle on.
- Rising-edge interrupt: TR_TYPE = 1, TR_LVL1 = 1, IRQ_ENA = 1; toggle gpio_i[0] 0→1 → TR_STAT = 1 and irq_o = 1. Write TR_STAT = 1 → TR_STAT = 0 and irq_o = 0.
- Errors: write to 0x0C, read of 0x3C, and access at 0x02 → PSLVERR = 1 and no register changes.

Source files
------------

// File: rtl/gpio_modport_pkg.sv
// Shared constants for the gpio_modport APB GPIO block: widths, offsets, register index.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package gpio_modport_pkg;

  localparam int DEF_PADDR_SIZE = 8;
  localparam int DEF_PDATA_SIZE = 32;

  // Byte offsets of the register file (PADDR[5:0])
  localparam logic [5:0] OFS_MODE    = 6'h00;
  localparam logic [5:0] OFS_DIR     = 6'h04;
  localparam logic [5:0] OFS_OUT     = 6'h08;
  localparam logic [5:0] OFS_IN      = 6'h0C;
  localparam logic [5:0] OFS_TR_TYPE = 6'h10;
  localparam logic [5:0] OFS_TR_LVL0 = 6'h14;
  localparam logic [5:0] OFS_TR_LVL1 = 6'h18;
  localparam logic [5:0] OFS_TR_STAT = 6'h1C;
  localparam logic [5:0] OFS_IRQ_ENA = 6'h20;

  // Register index as carried by PADDR[5:2]
  typedef enum logic [3:0] {
    REG_MODE    = 4'd0,
    REG_DIR     = 4'd1,
    REG_OUT     = 4'd2,
    REG_IN      = 4'd3,
    REG_TR_TYPE = 4'd4,
    REG_TR_LVL0 = 4'd5,
    REG_TR_LVL1 = 4'd6,
    REG_TR_STAT = 4'd7,
    REG_IRQ_ENA = 4'd8
  } reg_idx_e;

endpackage

// File: rtl/gpio_modport_sync.sv
// Two-flop synchronizer for asynchronous pad inputs plus a previous-value flop for edge detection.
// Latency: input captured at edge k is visible on s after edge k+1; p lags s by one cycle.
// Backpressure: none; samples every cycle.
module gpio_modport_sync #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] p
);

  logic [WIDTH-1:0] meta;

  // Metastability stage, stable stage and one-cycle history for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      s    <= '0;
      p    <= '0;
    end else begin
      meta <= d;
      s    <= meta;
      p    <= s;
    end
  end

endmodule

// File: rtl/gpio_modport.sv
// APB4 GPIO slave: per-pin direction, push-pull/open-drain, synced readback, optional IRQ (GPIO_IRQ_EN).
// Latency: zero-wait-state APB; writes visible on pads after the commit edge; input to IN in 2 edges.
// Backpressure: none; PREADY is tied high, illegal accesses answer with PSLVERR and are dropped.
module gpio_modport
  import gpio_modport_pkg::*;
#(
  parameter int PADDR_SIZE = DEF_PADDR_SIZE,
  parameter int PDATA_SIZE = DEF_PDATA_SIZE
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [PADDR_SIZE-1:0]   PADDR,
  input  logic                    PWRITE,
  input  logic [PDATA_SIZE/8-1:0] PSTRB,
  input  logic [PDATA_SIZE-1:0]   PWDATA,
  output logic [PDATA_SIZE-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  input  logic [PDATA_SIZE-1:0]   gpio_i,
  output logic [PDATA_SIZE-1:0]   gpio_o,
  output logic [PDATA_SIZE-1:0]   gpio_oe,
  output logic                    irq_o
);

  localparam int NB = PDATA_SIZE / 8;

  logic [5:0]            ofs;
  reg_idx_e              idx;
  logic                  mapped;
  logic                  bad;
  logic                  access;
  logic                  wr_commit;
  logic [PDATA_SIZE-1:0] wmask;
  logic [PDATA_SIZE-1:0] mode_q;
  logic [PDATA_SIZE-1:0] dir_q;
  logic [PDATA_SIZE-1:0] out_q;
  logic [PDATA_SIZE-1:0] sync_s;
  logic [PDATA_SIZE-1:0] sync_p;
  logic [PDATA_SIZE-1:0] rd_mux;
  logic                  unused_ok;

  assign ofs = PADDR[5:0];
  assign idx = reg_idx_e'(PADDR[5:2]);

  gpio_modport_sync #(.WIDTH(PDATA_SIZE)) u_sync (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .d     (gpio_i),
    .s     (sync_s),
    .p     (sync_p)
  );

  // Address decode: full 6-bit offset compare, so misaligned addresses are unmapped
  always_comb begin
    mapped = 1'b0;
    if (ofs == OFS_MODE || ofs == OFS_DIR || ofs == OFS_OUT || ofs == OFS_IN)
      mapped = 1'b1;
`ifdef GPIO_IRQ_EN
    if (ofs == OFS_TR_TYPE || ofs == OFS_TR_LVL0 || ofs == OFS_TR_LVL1 ||
        ofs == OFS_TR_STAT || ofs == OFS_IRQ_ENA)
      mapped = 1'b1;
`endif
  end

  assign bad       = ~mapped | (PWRITE & (ofs == OFS_IN));
  assign access    = PSEL & PENABLE;
  assign PREADY    = 1'b1;
  assign PSLVERR   = PRESETn & access & bad;
  assign wr_commit = access & PWRITE & ~bad;

  for (genvar b = 0; b < NB; b++) begin : g_wmask
    assign wmask[b*8 +: 8] = {8{PSTRB[b]}};
  end

  // Pad-control registers with byte-lane merge
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      mode_q <= '0;
      dir_q  <= '0;
      out_q  <= '0;
    end else if (wr_commit) begin
      case (idx)
        REG_MODE: mode_q <= (mode_q & ~wmask) | (PWDATA & wmask);
        REG_DIR:  dir_q  <= (dir_q  & ~wmask) | (PWDATA & wmask);
        REG_OUT:  out_q  <= (out_q  & ~wmask) | (PWDATA & wmask);
        default: ;
      endcase
    end
  end

  // Open-drain pins never drive high: they release (oe=0) for a 1 and pull low for a 0
  assign gpio_o  = out_q & ~mode_q;
  assign gpio_oe = dir_q & ~(mode_q & out_q);

`ifdef GPIO_IRQ_EN
  logic [PDATA_SIZE-1:0] tr_type_q;
  logic [PDATA_SIZE-1:0] lvl0_q;
  logic [PDATA_SIZE-1:0] lvl1_q;
  logic [PDATA_SIZE-1:0] stat_q;
  logic                  ena_q;
  logic [PDATA_SIZE-1:0] trig;
  logic [PDATA_SIZE-1:0] clr;

  // Per-pin trigger: edge pins compare current and previous synced value, level pins use current only
  always_comb begin
    trig = ( tr_type_q & ((lvl1_q & sync_s & ~sync_p) | (lvl0_q & ~sync_s & sync_p)))
         | (~tr_type_q & ((lvl1_q & sync_s) | (lvl0_q & ~sync_s)));
  end

  assign clr = (wr_commit && idx == REG_TR_STAT) ? (PWDATA & wmask) : '0;

  // Trigger configuration, global enable and sticky status (a new set beats a same-cycle clear)
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      tr_type_q <= '0;
      lvl0_q    <= '0;
      lvl1_q    <= '0;
      stat_q    <= '0;
      ena_q     <= 1'b0;
    end else begin
      if (wr_commit) begin
        case (idx)
          REG_TR_TYPE: tr_type_q <= (tr_type_q & ~wmask) | (PWDATA & wmask);
          REG_TR_LVL0: lvl0_q    <= (lvl0_q    & ~wmask) | (PWDATA & wmask);
          REG_TR_LVL1: lvl1_q    <= (lvl1_q    & ~wmask) | (PWDATA & wmask);
          REG_IRQ_ENA: if (PSTRB[0]) ena_q <= PWDATA[0];
          default: ;
        endcase
      end
      stat_q <= (stat_q & ~clr) | trig;
    end
  end

  assign irq_o     = ena_q & (|stat_q);
  assign unused_ok = ^PADDR[PADDR_SIZE-1:6];
`else
  assign irq_o     = 1'b0;
  assign unused_ok = ^{PADDR[PADDR_SIZE-1:6], sync_p};
`endif

  // Read-data selection for the addressed register
  always_comb begin
    rd_mux = '0;
    case (idx)
      REG_MODE:    rd_mux = mode_q;
      REG_DIR:     rd_mux = dir_q;
      REG_OUT:     rd_mux = out_q;
      REG_IN:      rd_mux = sync_s;
`ifdef GPIO_IRQ_EN
      REG_TR_TYPE: rd_mux = tr_type_q;
      REG_TR_LVL0: rd_mux = lvl0_q;
      REG_TR_LVL1: rd_mux = lvl1_q;
      REG_TR_STAT: rd_mux = stat_q;
      REG_IRQ_ENA: rd_mux = {{(PDATA_SIZE-1){1'b0}}, ena_q};
`endif
      default:     rd_mux = '0;
    endcase
  end

  assign PRDATA = (PRESETn & PSEL & ~PWRITE & mapped) ? rd_mux : '0;

endmodule

// File: tb/tb_gpio_modport.sv
// Self-checking bench for gpio_modport: directed vector table, timing sequences, randomized model check.
// Adapts to builds with and without GPIO_IRQ_EN.
module tb_gpio_modport;

  logic        PCLK;
  logic        PRESETn;
  logic        PSEL;
  logic        PENABLE;
  logic [7:0]  PADDR;
  logic        PWRITE;
  logic [3:0]  PSTRB;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] gpio_i;
  logic [31:0] gpio_o;
  logic [31:0] gpio_oe;
  logic        irq_o;

  gpio_modport dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PSTRB   (PSTRB),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe),
    .irq_o   (irq_o)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

`ifdef GPIO_IRQ_EN
  localparam logic [5:0] TOP_OFS = 6'h20;
`else
  localparam logic [5:0] TOP_OFS = 6'h0C;
`endif

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] exp_o;
    logic [31:0] exp_oe;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: MODE, DIR, OUT and the settled input value
  logic [31:0] m_reg [3];
  logic [31:0] m_in;

  logic [31:0] rdata;
  logic        err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                              input logic [3:0] st, input logic e, input logic [31:0] rd,
                              input logic [31:0] o, input logic [31:0] oe);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = wd; v.strb = st;
    v.exp_err = e; v.exp_rdata = rd; v.exp_o = o; v.exp_oe = oe;
    return v;
  endfunction

  // Error rule: misaligned, beyond the implemented map, or a write to IN
  function automatic logic exp_err(input logic wr, input logic [7:0] a);
    logic [5:0] o;
    o = a[5:0];
    if (o[1:0] != 2'b00) return 1'b1;
    if (o > TOP_OFS) return 1'b1;
    if (wr && o == 6'h0C) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a[5:0])
      6'h00:   return m_reg[0];
      6'h04:   return m_reg[1];
      6'h08:   return m_reg[2];
      6'h0C:   return m_in;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_write(input logic [7:0] a, input logic [31:0] wd, input logic [3:0] st);
    int r;
    r = int'(a[3:2]);
    for (int b = 0; b < 4; b++)
      if (st[b]) m_reg[r][b*8 +: 8] = wd[b*8 +: 8];
  endtask

  // Pin-by-pin expectation from MODE/DIR/OUT
  task automatic check_pins(input string tag);
    logic [31:0] eo, eoe;
    for (int i = 0; i < 32; i++) begin
      if (m_reg[0][i]) begin
        eo[i]  = 1'b0;
        eoe[i] = m_reg[1][i] && !m_reg[2][i];
      end else begin
        eo[i]  = m_reg[2][i];
        eoe[i] = m_reg[1][i];
      end
    end
    check({tag, "_o"}, gpio_o, eo);
    check({tag, "_oe"}, gpio_oe, eoe);
  endtask

  task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                     input logic [3:0] st, output logic [31:0] rd, output logic e);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd; PSTRB = st;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    rd = PRDATA;
    e  = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = 4'h0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl [17];

  initial begin
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 8'h0; PSTRB = 4'h0; PWDATA = 32'h0; gpio_i = 32'h0;
    m_reg[0] = 32'h0; m_reg[1] = 32'h0; m_reg[2] = 32'h0; m_in = 32'h0;

    tbl[0]  = mk(1'b0, 8'h00, 32'h0,        4'h0, 1'b0, 32'h0,    32'h0,    32'h0);
    tbl[1]  = mk(1'b0, 8'h04, 32'h0,        4'h0, 1'b0, 32'h0,    32'h0,    32'h0);
    tbl[2]  = mk(1'b0, 8'h08, 32'h0,        4'h0, 1'b0, 32'h0,    32'h0,    32'h0);
    tbl[3]  = mk(1'b0, 8'h0C, 32'h0,        4'h0, 1'b0, 32'h0,    32'h0,    32'h0);
    tbl[4]  = mk(1'b1, 8'h04, 32'h0000_00FF, 4'hF, 1'b0, 32'h0,    32'h0,    32'hFF);
    tbl[5]  = mk(1'b1, 8'h08, 32'h0000_00A5, 4'hF, 1'b0, 32'h0,    32'hA5,   32'hFF);
    tbl[6]  = mk(1'b1, 8'h00, 32'h0000_00FF, 4'hF, 1'b0, 32'h0,    32'h0,    32'h5A);
    tbl[7]  = mk(1'b0, 8'h00, 32'h0,        4'h0, 1'b0, 32'hFF,   32'h0,    32'h5A);
    tbl[8]  = mk(1'b1, 8'h00, 32'h0,        4'hF, 1'b0, 32'h0,    32'hA5,   32'hFF);
    tbl[9]  = mk(1'b1, 8'h08, 32'h0,        4'hF, 1'b0, 32'h0,    32'h0,    32'hFF);
    tbl[10] = mk(1'b1, 8'h08, 32'hFFFF_FFFF, 4'h2, 1'b0, 32'h0,    32'hFF00, 32'hFF);
    tbl[11] = mk(1'b0, 8'h08, 32'h0,        4'h0, 1'b0, 32'hFF00, 32'hFF00, 32'hFF);
    tbl[12] = mk(1'b1, 8'h0C, 32'h0000_1234, 4'hF, 1'b1, 32'h0,    32'hFF00, 32'hFF);
    tbl[13] = mk(1'b0, 8'h3C, 32'h0,        4'h0, 1'b1, 32'h0,    32'hFF00, 32'hFF);
    tbl[14] = mk(1'b1, 8'h02, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0,    32'hFF00, 32'hFF);
    tbl[15] = mk(1'b0, 8'h00, 32'h0,        4'h0, 1'b0, 32'h0,    32'hFF00, 32'hFF);
`ifdef GPIO_IRQ_EN
    tbl[16] = mk(1'b0, 8'h10, 32'h0,        4'h0, 1'b0, 32'h0,    32'hFF00, 32'hFF);
`else
    tbl[16] = mk(1'b0, 8'h10, 32'h0,        4'h0, 1'b1, 32'h0,    32'hFF00, 32'hFF);
`endif

    // Reset: a transfer issued while in reset must be ignored
    apb(1'b1, 8'h04, 32'hFFFF_FFFF, 4'hF, rdata, err);
    check("reset_pslverr", {31'h0, err}, 32'h0);
    @(negedge PCLK);
    check("reset_oe", gpio_oe, 32'h0);
    check("reset_o", gpio_o, 32'h0);
    check("reset_irq", {31'h0, irq_o}, 32'h0);
    check("pready", {31'h0, PREADY}, 32'h1);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;

    // Directed vector table
    for (int i = 0; i < 17; i++) begin
      apb(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, rdata, err);
      check($sformatf("tbl%0d_err", i), {31'h0, err}, {31'h0, tbl[i].exp_err});
      if (!tbl[i].wr) check($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rdata);
      @(negedge PCLK);
      check($sformatf("tbl%0d_o", i), gpio_o, tbl[i].exp_o);
      check($sformatf("tbl%0d_oe", i), gpio_oe, tbl[i].exp_oe);
      if (tbl[i].wr && !tbl[i].exp_err) m_write(tbl[i].addr, tbl[i].wdata, tbl[i].strb);
    end

    // Input synchronizer latency: IN held selected while gpio_i changes
    @(posedge PCLK); #1;
    gpio_i = 32'h1234_5678; PSEL = 1'b1; PWRITE = 1'b0; PADDR = 8'h0C; PENABLE = 1'b0;
    @(negedge PCLK); check("in_before_capture", PRDATA, 32'h0);
    @(negedge PCLK); check("in_after_first_edge", PRDATA, 32'h0);
    @(negedge PCLK); check("in_after_second_edge", PRDATA, 32'h1234_5678);
    @(posedge PCLK); #1;
    PSEL = 1'b0;
    m_in = 32'h1234_5678;

`ifdef GPIO_IRQ_EN
    // Rising-edge interrupt on pin 0, then W1C, then level mode and global enable
    apb(1'b1, 8'h10, 32'h1, 4'hF, rdata, err);
    apb(1'b1, 8'h18, 32'h1, 4'hF, rdata, err);
    apb(1'b1, 8'h20, 32'h1, 4'hF, rdata, err);
    apb(1'b0, 8'h1C, 32'h0, 4'h0, rdata, err);
    check("stat_idle", rdata, 32'h0);
    check("irq_idle", {31'h0, irq_o}, 32'h0);
    @(posedge PCLK); #1;
    gpio_i[0] = 1'b1;
    @(negedge PCLK); check("irq_pre_k", {31'h0, irq_o}, 32'h0);
    @(negedge PCLK); check("irq_after_k", {31'h0, irq_o}, 32'h0);
    @(negedge PCLK); check("irq_after_k1", {31'h0, irq_o}, 32'h0);
    @(negedge PCLK); check("irq_after_k2", {31'h0, irq_o}, 32'h1);
    apb(1'b0, 8'h1C, 32'h0, 4'h0, rdata, err);
    check("stat_set", rdata, 32'h1);
    apb(1'b1, 8'h1C, 32'h1, 4'hF, rdata, err);
    @(negedge PCLK); check("irq_cleared", {31'h0, irq_o}, 32'h0);
    apb(1'b0, 8'h1C, 32'h0, 4'h0, rdata, err);
    check("stat_cleared", rdata, 32'h0);
    apb(1'b0, 8'h20, 32'h0, 4'h0, rdata, err);
    check("irq_ena_rd", rdata, 32'h1);
    apb(1'b1, 8'h10, 32'h0, 4'hF, rdata, err);
    apb(1'b0, 8'h1C, 32'h0, 4'h0, rdata, err);
    check("level_stat", rdata, 32'h1);
    check("level_irq", {31'h0, irq_o}, 32'h1);
    apb(1'b1, 8'h20, 32'h0, 4'hF, rdata, err);
    @(negedge PCLK); check("irq_gated", {31'h0, irq_o}, 32'h0);
`else
    // Interrupt logic absent: irq stays low and its offsets error out
    @(posedge PCLK); #1;
    gpio_i[0] = 1'b1;
    repeat (4) @(posedge PCLK);
    @(negedge PCLK); check("irq_absent", {31'h0, irq_o}, 32'h0);
    apb(1'b1, 8'h1C, 32'h1, 4'hF, rdata, err);
    check("stat_wr_err", {31'h0, err}, 32'h1);
    apb(1'b0, 8'h20, 32'h0, 4'h0, rdata, err);
    check("ena_rd_err", {31'h0, err}, 32'h1);
    check("ena_rd_data", rdata, 32'h0);
`endif
    repeat (3) @(posedge PCLK);
    m_in = gpio_i;

    // Randomized accesses against the reference model
    for (int n = 0; n < 300; n++) begin
      logic [7:0]  a;
      logic        wr, e;
      logic [31:0] wd;
      logic [3:0]  st;
      int          r;
      if (n % 25 == 0) begin
        @(posedge PCLK); #1;
        gpio_i = $urandom;
        repeat (3) @(posedge PCLK);
        m_in = gpio_i;
      end
      r = $urandom_range(0, 10);
      if (r > 3) r = r + 5;
      a = 8'(r * 4);
      if ($urandom_range(0, 7) == 0) a = a | 8'($urandom_range(1, 3));
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      st = 4'($urandom_range(0, 15));
      apb(wr, a, wd, st, rdata, err);
      e = exp_err(wr, a);
      check("rnd_err", {31'h0, err}, {31'h0, e});
      if (!wr) check("rnd_rdata", rdata, e ? 32'h0 : m_read(a));
      if (wr && !e) m_write(a, wd, st);
      @(negedge PCLK);
      check_pins("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
